// File: rtl/fx3_cmd_pkg.sv
// fx3_cmd_pkg: parser states, opcodes and command-word field positions
package fx3_cmd_pkg;
  typedef enum logic [2:0] {S_HDR, S_CMD, S_ARG, S_CRC, S_DRAIN} state_t;
  localparam logic [7:0] OP_SET_PACKETS = 8'h01;
  localparam logic [7:0] OP_SET_LED     = 8'h02;
  localparam logic [7:0] OP_CTR_RESET   = 8'h03;
  localparam int OPCODE_LSB = 24;
  localparam int NARGS_LSB  = 16;
endpackage

// File: rtl/fx3_cmd_parser.sv
// fx3_cmd_parser: frames FX3 read-path words into command packets and commits control registers
module fx3_cmd_parser
  import fx3_cmd_pkg::*;
#(
  parameter logic [31:0] HEADER   = 32'hCAFEB0BA,
  parameter int          MAX_ARGS = 4
) (
  input  logic        clk_pll,
  input  logic        reset_,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_opcode,
  output logic [31:0] packets_to_send,
  output logic [3:0]  led_out,
  output logic        ctr_reset,
  output logic [15:0] cmd_count,
  output logic [15:0] err_count
);
  localparam logic [7:0] MAX_N = 8'(MAX_ARGS);
  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d, arg0_q, arg0_d, packets_q, packets_d;
  logic [7:0]  op_q, op_d, nargs_q, nargs_d, cmd_opcode_q, cmd_opcode_d;
  logic [3:0]  idx_q, idx_d, led_q, led_d;
  logic [15:0] cmd_count_q, cmd_count_d, err_count_q, err_count_d;
  logic        cmd_valid_q, cmd_valid_d, ctr_reset_q, ctr_reset_d;
  logic        err_inc, commit, abort, missing_arg;
  logic [7:0]  w_nargs;
  assign w_nargs     = in_data[NARGS_LSB +: 8];
  assign missing_arg = nargs_q == 8'd0 && (op_q == OP_SET_PACKETS || op_q == OP_SET_LED);
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    nargs_d = nargs_q;
    idx_d   = idx_q;
    arg0_d  = arg0_q;
    err_inc = 1'b0;
    commit  = 1'b0;
    abort   = !in_valid && (state_q == S_CMD || state_q == S_ARG || state_q == S_CRC);
    case (state_q)
      S_HDR: if (in_valid) begin
        acc_d   = in_data;
        state_d = in_data == HEADER ? S_CMD : S_DRAIN;
        err_inc = in_data != HEADER;
      end
      S_CMD: if (in_valid) begin
        op_d    = in_data[OPCODE_LSB +: 8];
        nargs_d = w_nargs;
        acc_d   = acc_q ^ in_data;
        idx_d   = 4'd0;
        state_d = w_nargs > MAX_N ? S_DRAIN : w_nargs == 8'd0 ? S_CRC : S_ARG;
        err_inc = w_nargs > MAX_N;
      end
      S_ARG: if (in_valid) begin
        acc_d   = acc_q ^ in_data;
        arg0_d  = idx_q == 4'd0 ? in_data : arg0_q;
        idx_d   = idx_q + 4'd1;
        state_d = {4'd0, idx_q} == nargs_q - 8'd1 ? S_CRC : S_ARG;
      end
      S_CRC: if (in_valid) begin
        acc_d   = '0;
        state_d = S_HDR;
        commit  = in_data == acc_q && !missing_arg;
        err_inc = !commit;
      end
      S_DRAIN: state_d = in_valid ? S_DRAIN : S_HDR;
      default: state_d = S_HDR;
    endcase
    if (abort) begin
      state_d = S_HDR;
      acc_d   = '0;
      err_inc = 1'b1;
    end
  end
  // Register commit: opcode actions land together with the cmd_valid pulse
  always_comb begin
    cmd_valid_d  = commit;
    ctr_reset_d  = commit && op_q == OP_CTR_RESET;
    cmd_opcode_d = commit ? op_q : cmd_opcode_q;
    cmd_count_d  = commit ? cmd_count_q + 16'd1 : cmd_count_q;
    packets_d    = commit && op_q == OP_SET_PACKETS ? arg0_q : packets_q;
    led_d        = commit && op_q == OP_SET_LED ? arg0_q[3:0] : led_q;
    err_count_d  = err_inc && err_count_q != 16'hFFFF ? err_count_q + 16'd1 : err_count_q;
  end
  always_ff @(posedge clk_pll or negedge reset_) begin
    if (!reset_) begin
      state_q      <= S_HDR;
      acc_q        <= '0;
      op_q         <= '0;
      nargs_q      <= '0;
      idx_q        <= '0;
      arg0_q       <= '0;
      cmd_valid_q  <= 1'b0;
      ctr_reset_q  <= 1'b0;
      cmd_opcode_q <= '0;
      cmd_count_q  <= '0;
      err_count_q  <= '0;
      packets_q    <= '0;
      led_q        <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      op_q         <= op_d;
      nargs_q      <= nargs_d;
      idx_q        <= idx_d;
      arg0_q       <= arg0_d;
      cmd_valid_q  <= cmd_valid_d;
      ctr_reset_q  <= ctr_reset_d;
      cmd_opcode_q <= cmd_opcode_d;
      cmd_count_q  <= cmd_count_d;
      err_count_q  <= err_count_d;
      packets_q    <= packets_d;
      led_q        <= led_d;
    end
  end
  assign cmd_valid       = cmd_valid_q;
  assign ctr_reset       = ctr_reset_q;
  assign cmd_opcode      = cmd_opcode_q;
  assign cmd_count       = cmd_count_q;
  assign err_count       = err_count_q;
  assign packets_to_send = packets_q;
  assign led_out         = led_q;
endmodule

// File: tb/tb_fx3_cmd_parser.sv
// tb_fx3_cmd_parser: random bursts of well-formed and broken packets checked against a packet-level model
module tb_fx3_cmd_parser;
  localparam logic [31:0] HDR = 32'hCAFEB0BA;
  localparam int MAXA = 4;
  logic        clk_pll = 1'b0, reset_ = 1'b0, in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        cmd_valid, ctr_reset;
  logic [7:0]  cmd_opcode;
  logic [31:0] packets_to_send;
  logic [3:0]  led_out;
  logic [15:0] cmd_count, err_count;
  fx3_cmd_parser #(.HEADER(HDR), .MAX_ARGS(MAXA)) dut (
    .clk_pll(clk_pll), .reset_(reset_), .in_valid(in_valid), .in_data(in_data),
    .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode), .packets_to_send(packets_to_send),
    .led_out(led_out), .ctr_reset(ctr_reset), .cmd_count(cmd_count), .err_count(err_count)
  );
  always #5 clk_pll = ~clk_pll;
  int nchk = 0, nerr = 0;
  logic [31:0] wq[$], argq[$];
  int          evq[$];
  logic [7:0]  opq[$];
  bit          trunc = 1'b0;
  logic [31:0] m_pkts = '0;
  logic [3:0]  m_led = '0;
  logic [15:0] m_cmd = '0, m_err = '0;
  logic [7:0]  m_op = '0;
  logic        m_valid = 1'b0, m_ctr = 1'b0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    check("cmd_valid", 32'(cmd_valid), 32'(m_valid));
    check("ctr_reset", 32'(ctr_reset), 32'(m_ctr));
    check("cmd_opcode", 32'(cmd_opcode), 32'(m_op));
    check("packets_to_send", packets_to_send, m_pkts);
    check("led_out", 32'(led_out), 32'(m_led));
    check("cmd_count", 32'(cmd_count), 32'(m_cmd));
    check("err_count", 32'(err_count), 32'(m_err));
  endtask
  task automatic model_reset();
    m_pkts = '0; m_led = '0; m_cmd = '0; m_err = '0; m_op = '0; m_valid = 1'b0; m_ctr = 1'b0;
  endtask
  task automatic bump_err();
    if (m_err != 16'hFFFF) m_err++;
  endtask
  // ev: 0 nothing, 1 packet commits on this word, 2 packet rejected on this word
  task automatic push(input logic [31:0] d, input int ev, input logic [7:0] op, input logic [31:0] a);
    wq.push_back(d); evq.push_back(ev); opq.push_back(op); argq.push_back(a);
  endtask
  // kind: 0 intact, 1 corrupted checksum, 2 burst ends after cut words (cut 0 = random)
  task automatic pkt(input int kind, input logic [7:0] op, input int n, input logic [31:0] a0, input int cut);
    logic [31:0] w[$];
    logic [31:0] crc;
    bit bad;
    int k;
    w.push_back(HDR);
    w.push_back({op, 8'(n), 16'h0000});
    for (int i = 0; i < n; i++) w.push_back(i == 0 ? a0 : $urandom);
    crc = '0;
    foreach (w[i]) crc ^= w[i];
    w.push_back(kind == 1 ? crc ^ (32'h1 << $urandom_range(31, 0)) : crc);
    if (kind == 2) begin
      k = cut > 0 ? cut : $urandom_range(w.size() - 1, 1);
      for (int i = 0; i < k; i++) push(w[i], 0, op, a0);
      trunc = 1'b1;
      return;
    end
    bad = kind == 1 || (n == 0 && (op == 8'h01 || op == 8'h02));
    foreach (w[i]) push(w[i], i == w.size() - 1 ? (bad ? 2 : 1) : 0, op, a0);
  endtask
  task automatic badhdr(input logic [31:0] d, input int extra);
    push(d, 2, 0, 0);
    for (int i = 0; i < extra; i++) push($urandom, 0, 0, 0);
  endtask
  task automatic toomany(input int n, input int extra);
    push(HDR, 0, 0, 0);
    push({8'($urandom), 8'(n), 16'h0000}, 2, 0, 0);
    for (int i = 0; i < extra; i++) push($urandom, 0, 0, 0);
  endtask
  task automatic idle(input bit aborts);
    in_valid = 1'b0;
    in_data  = $urandom;
    @(posedge clk_pll); #1;
    m_valid = 1'b0; m_ctr = 1'b0;
    if (aborts) bump_err();
    check_all();
  endtask
  task automatic run_burst();
    foreach (wq[i]) begin
      in_valid = 1'b1;
      in_data  = wq[i];
      @(posedge clk_pll); #1;
      m_valid = evq[i] == 1;
      m_ctr   = evq[i] == 1 && opq[i] == 8'h03;
      if (evq[i] == 1) begin
        m_op = opq[i];
        m_cmd++;
        if (opq[i] == 8'h01) m_pkts = argq[i];
        if (opq[i] == 8'h02) m_led = argq[i][3:0];
      end
      if (evq[i] == 2) bump_err();
      check_all();
    end
    idle(trunc);
    repeat ($urandom_range(2, 0)) idle(1'b0);
    wq.delete(); evq.delete(); opq.delete(); argq.delete();
    trunc = 1'b0;
  endtask
  task automatic rand_pkt(input int kind);
    logic [7:0] op;
    op = $urandom_range(3) == 0 ? 8'($urandom) : 8'($urandom_range(4, 0));
    pkt(kind, op, $urandom_range(MAXA, 0), $urandom, 0);
  endtask
  initial begin
    logic [31:0] d;
    repeat (2) @(posedge clk_pll);
    #1;
    check_all();
    reset_ = 1'b1;
    idle(1'b0);
    pkt(0, 8'h01, 1, 32'd5, 0); run_burst();
    check("set_packets_5", packets_to_send, 32'd5);
    pkt(1, 8'h01, 1, 32'd5, 0); run_burst();
    pkt(0, 8'h02, 1, 32'hA, 0); pkt(0, 8'h03, 0, 0, 0); run_burst();
    check("led_a", 32'(led_out), 32'hA);
    badhdr(32'h12345678, 3); run_burst();
    pkt(0, 8'h01, 1, 32'd7, 0); run_burst();
    pkt(2, 8'h01, 1, 32'd9, 2); run_burst();
    pkt(0, 8'h01, 1, 32'd11, 0); run_burst();
    toomany(5, 3); run_burst();
    pkt(0, 8'h02, 0, 0, 0); run_burst();
    for (int b = 0; b < 300; b++) begin
      repeat ($urandom_range(3, 0)) rand_pkt($urandom_range(4) == 0 ? 1 : 0);
      case ($urandom_range(4, 0))
        1: begin
          do d = $urandom; while (d == HDR);
          badhdr(d, $urandom_range(3, 0));
        end
        2: toomany($urandom_range(255, MAXA + 1), $urandom_range(4, 0));
        3: rand_pkt(2);
        default: ;
      endcase
      run_burst();
    end
    pkt(0, 8'h02, 1, 32'h5, 0); run_burst();
    in_valid = 1'b1;
    in_data  = HDR;
    @(posedge clk_pll); #1;
    in_data = {8'h01, 8'h01, 16'h0000};
    @(posedge clk_pll); #1;
    reset_ = 1'b0;
    #1;
    model_reset();
    check_all();
    in_valid = 1'b0;
    @(posedge clk_pll); #1;
    check_all();
    reset_ = 1'b1;
    pkt(0, 8'h01, 1, 32'd3, 0); run_burst();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/fx3_cmd_parser.md
Name: fx3_cmd_parser

Overview:
- Downstream consumer of the FX3 slave-FIFO read path.
- Takes the registered 32-bit word stream the loopback read pipeline produces: word valid is the delayed SLRD strobe, data is the flopped DQ.
- Frames command packets, validates header, length and checksum, then commits control registers: packets_to_send, user LEDs and counter reset.
- Replaces the ad-hoc header check in the top level; the write-side state machine reads packets_to_send from here.

Parameters:
HEADER, 32'hCAFEB0BA, required first word of every packet
MAX_ARGS, 4, maximum argument words per packet (1..15)

Ports:
clk_pll  input  1  100 MHz PLL clock
reset_  input  1  asynchronous, active-low reset
in_valid  input  1  word strobe; high for the duration of one FX3 read burst
in_data  input  32  word, sampled when in_valid=1
cmd_valid  output  1  one-cycle pulse, a well-formed packet was committed
cmd_opcode  output  8  opcode of the last committed packet
packets_to_send  output  32  count for the write-side state machine
led_out  output  4  user LED value
ctr_reset  output  1  one-cycle pulse clearing the global counters
cmd_count  output  16  committed packets, wraps at 0xFFFF->0
err_count  output  16  rejected packets, saturates at 0xFFFF

Behaviour:
- Clocking and reset:
  - All state is on clk_pll, with reset_ asynchronous and active-low.
  - Reset values: every output 0; state S_HDR; checksum accumulator 0.
- Packet format, one word per in_valid cycle:
  - w0 = HEADER
  - w1 = {opcode[31:24], nargs[23:16], 16'h0000}
  - w2..w(1+nargs) = arguments
  - final word = XOR of all preceding words of the packet
- Several packets may occupy one burst, back-to-back with no gap.
- States:
  - S_HDR:
    - in_valid & word==HEADER -> S_CMD; acc<=word.
    - in_valid & word!=HEADER -> S_DRAIN, err++.
  - S_CMD:
    - nargs>MAX_ARGS -> S_DRAIN, err++.
    - nargs==0 -> S_CRC.
    - else -> S_ARG.
    - Latch opcode and nargs; acc^=word.
  - S_ARG:
    - Store the word in args[idx]; acc^=word; idx++.
    - When idx==nargs-1 -> S_CRC.
  - S_CRC:
    - word==acc -> commit, then S_HDR.
    - word!=acc -> err++, no commit, then S_HDR.
  - S_DRAIN: ignore words until in_valid=0, then S_HDR.
- Burst end: in_valid=0 while in S_CMD, S_ARG or S_CRC:
  - Abort the packet, err++, go to S_HDR, clear acc.
  - in_valid=0 in S_HDR causes no error.
- Commit timing: the commit is registered, so effects are visible on the cycle after the checksum word is sampled:
  - cmd_valid=1 for exactly one cycle.
  - cmd_opcode updated.
  - cmd_count++.
- Opcode actions, applied at commit:
  - 0x01 SET_PACKETS: packets_to_send<=args[0].
  - 0x02 SET_LED: led_out<=args[0][3:0].
  - 0x03 CTR_RESET: ctr_reset=1 for one cycle, aligned with cmd_valid.
  - Other opcode: cmd_valid pulses, no register change.
- Missing argument: opcode 0x01 or 0x02 with nargs==0 is an error:
  - err++.
  - No cmd_valid, no register change.
- Simultaneous events: a commit and a new header word on the next cycle are both honoured, with no dead cycle between packets.
- err_count: at most one increment per cycle.
- Reset mid-packet: the partial packet is discarded, and packets_to_send and led_out return to 0.

Decomposition:
- Package fx3_cmd_pkg holds:
  - the state enum;
  - opcode constants OP_SET_PACKETS=8'h01, OP_SET_LED=8'h02, OP_CTR_RESET=8'h03;
  - field position localparams for w1.
- No sub-module: framing, checksum and register commit form a single module of roughly 200 lines.

Test Plan:
- Burst {CAFEB0BA, 01010000, 00000005, CAFEB0BA^01010000^00000005}:
  - packets_to_send=5 and cmd_valid pulse one cycle after the last word.
  - cmd_count=1.
- The same packet with the checksum word flipped in bit 0:
  - err_count=1.
  - packets_to_send unchanged, no cmd_valid.
- One burst carrying SET_LED(arg 0x0000000A) then CTR_RESET (nargs=0), back-to-back:
  - led_out=4'hA.
  - ctr_reset pulse.
  - cmd_count +2.
- First word 12345678, followed by 3 more words in the same burst:
  - err_count +1 only.
  - Parser recovers and accepts a valid packet in the next burst.
- in_valid drops after w1 of a SET_PACKETS packet:
  - err_count +1, state S_HDR.
  - Next burst parses normally.
- nargs=5 with MAX_ARGS=4 → err +1, drain to end of burst.
- reset_ asserted mid-packet → all outputs 0.
